// File: rtl/priority_resolver_isr_pkg.sv
// Shared types, constants and helpers for the priority resolver / ISR block.
// Priority order starts at (lowest_pri + 1) and wraps around the 8 levels.
package pic_pkg;

  localparam int IR_COUNT = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACK1 = 2'd1;
  localparam state_t ACK2 = 2'd2;

  localparam int OCW2_R_BIT   = 7;
  localparam int OCW2_SL_BIT  = 6;
  localparam int OCW2_EOI_BIT = 5;
  localparam int OCW2_L_MSB   = 2;

  // Command codes as {R, SL, EOI}
  localparam logic [2:0] CMD_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] CMD_NS_EOI       = 3'b001;
  localparam logic [2:0] CMD_NOP          = 3'b010;
  localparam logic [2:0] CMD_SP_EOI       = 3'b011;
  localparam logic [2:0] CMD_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] CMD_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] CMD_SET_PRI      = 3'b110;
  localparam logic [2:0] CMD_ROT_SP_EOI   = 3'b111;

  // Returns {found, level} of the highest-priority set bit.
  function automatic logic [3:0] rotPriority(input logic [7:0] vec,
                                             input logic [2:0] lowest_pri);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    // Walk from lowest to highest priority; the last hit is the winner.
    for (int i = IR_COUNT - 1; i >= 0; i--) begin
      idx = lowest_pri + 3'(i + 1);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // 0 = highest priority, 7 = lowest.
  function automatic logic [2:0] priRank(input logic [2:0] level,
                                         input logic [2:0] lowest_pri);
    return level - lowest_pri - 3'd1;
  endfunction

endpackage

// File: rtl/priority_resolver_isr_if.sv
// Request/INTA/OCW2/vector bundle between the resolver and its neighbours.
interface priority_resolver_isr_if;
  logic [7:0] risedBits;
  logic [7:0] bitToMask;
  logic       intaPulse;
  logic [4:0] icw2Vector;
  logic       aeoi;
  logic       ocw2Valid;
  logic [7:0] ocw2;
  logic       intOut;
  logic [2:0] resetIRR;
  logic       readPriority;
  logic [7:0] vectorOut;
  logic       vectorValid;
  logic [7:0] isrOut;

  modport master (
    output risedBits, bitToMask, intaPulse, icw2Vector, aeoi, ocw2Valid, ocw2,
    input  intOut, resetIRR, readPriority, vectorOut, vectorValid, isrOut
  );

  modport slave (
    input  risedBits, bitToMask, intaPulse, icw2Vector, aeoi, ocw2Valid, ocw2,
    output intOut, resetIRR, readPriority, vectorOut, vectorValid, isrOut
  );
endinterface

// File: rtl/priority_resolver_isr_priority_encoder_rot.sv
// Combinational rotating first-set-bit finder.
module priority_encoder_rot
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  logic [2:0] lowest_pri,
  output logic       found,
  output logic [2:0] level
);
  logic [3:0] res;

  always_comb begin
    res   = rotPriority(vec, lowest_pri);
    found = res[3];
    level = res[2:0];
  end
endmodule

// File: rtl/priority_resolver_isr.sv
// Priority resolution, In-Service Register, INTA sequencing and OCW2 handling.
module priority_resolver_isr
  import pic_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  priority_resolver_isr_if.slave bus
);
  state_t     state_q, state_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] lowest_pri_q, lowest_pri_d;
  logic       rotate_aeoi_q, rotate_aeoi_d;
  logic       int_q, int_d;
  logic [2:0] reset_irr_q, reset_irr_d;
  logic       read_pri_q, read_pri_d;
  logic [7:0] vector_q, vector_d;
  logic       vector_valid_q, vector_valid_d;
  logic [2:0] lvl_q, lvl_d;
  logic       spurious_q, spurious_d;

  logic [7:0] pend;
  logic       cand_found, cur_found;
  logic [2:0] cand_level, cur_level;
  logic       request;
  logic [2:0] ocw2_cmd, ocw2_l;
  logic [7:0] isr_set, isr_clr;
  logic       ocw2_unused;

  assign pend        = bus.risedBits & ~bus.bitToMask;
  assign ocw2_cmd    = {bus.ocw2[OCW2_R_BIT], bus.ocw2[OCW2_SL_BIT], bus.ocw2[OCW2_EOI_BIT]};
  assign ocw2_l      = bus.ocw2[OCW2_L_MSB:0];
  assign ocw2_unused = ^bus.ocw2[4:3];

  priority_encoder_rot u_cand_enc (
    .vec        (pend),
    .lowest_pri (lowest_pri_q),
    .found      (cand_found),
    .level      (cand_level)
  );

  priority_encoder_rot u_isr_enc (
    .vec        (isr_q),
    .lowest_pri (lowest_pri_q),
    .found      (cur_found),
    .level      (cur_level)
  );

  // An equal level in service blocks a new request.
  assign request = cand_found &&
                   (!cur_found || (priRank(cand_level, lowest_pri_q) <
                                   priRank(cur_level, lowest_pri_q)));

  always_comb begin
    state_d        = state_q;
    lowest_pri_d   = lowest_pri_q;
    rotate_aeoi_d  = rotate_aeoi_q;
    int_d          = int_q;
    reset_irr_d    = reset_irr_q;
    read_pri_d     = 1'b0;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;
    lvl_d          = lvl_q;
    spurious_d     = spurious_q;
    isr_set        = 8'h00;
    isr_clr        = 8'h00;

    if (bus.ocw2Valid) begin
      case (ocw2_cmd)
        CMD_NS_EOI:       if (cur_found) isr_clr = 8'b1 << cur_level;
        CMD_SP_EOI:       isr_clr = 8'b1 << ocw2_l;
        CMD_ROT_NS_EOI:   if (cur_found) begin
                            isr_clr      = 8'b1 << cur_level;
                            lowest_pri_d = cur_level;
                          end
        CMD_ROT_SP_EOI:   begin
                            isr_clr      = 8'b1 << ocw2_l;
                            lowest_pri_d = ocw2_l;
                          end
        CMD_SET_PRI:      lowest_pri_d = ocw2_l;
        CMD_ROT_AEOI_SET: rotate_aeoi_d = 1'b1;
        CMD_ROT_AEOI_CLR: rotate_aeoi_d = 1'b0;
        default:          ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (request) begin
          int_d   = 1'b1;
          state_d = ACK1;
        end
      end
      ACK1: begin
        if (bus.intaPulse) begin
          if (cand_found) begin
            lvl_d       = cand_level;
            spurious_d  = 1'b0;
            isr_set     = 8'b1 << cand_level;
            reset_irr_d = cand_level;
            read_pri_d  = 1'b1;
          end else begin
            lvl_d      = SPURIOUS_LEVEL;
            spurious_d = 1'b1;
          end
          state_d = ACK2;
        end
      end
      ACK2: begin
        if (bus.intaPulse) begin
          vector_d       = {bus.icw2Vector, lvl_q};
          vector_valid_d = 1'b1;
          int_d          = 1'b0;
          state_d        = IDLE;
          if (bus.aeoi && !spurious_q) begin
            isr_clr = isr_clr | (8'b1 << lvl_q);
            if (rotate_aeoi_q) lowest_pri_d = lvl_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new in-service bit wins over a same-cycle EOI on that bit.
    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      isr_q          <= 8'h00;
      lowest_pri_q   <= 3'd7;
      rotate_aeoi_q  <= 1'b0;
      int_q          <= 1'b0;
      reset_irr_q    <= 3'd0;
      read_pri_q     <= 1'b0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      lvl_q          <= 3'd0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      isr_q          <= isr_d;
      lowest_pri_q   <= lowest_pri_d;
      rotate_aeoi_q  <= rotate_aeoi_d;
      int_q          <= int_d;
      reset_irr_q    <= reset_irr_d;
      read_pri_q     <= read_pri_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      lvl_q          <= lvl_d;
      spurious_q     <= spurious_d;
    end
  end

  assign bus.intOut       = int_q;
  assign bus.resetIRR     = reset_irr_q;
  assign bus.readPriority = read_pri_q;
  assign bus.vectorOut    = vector_q;
  assign bus.vectorValid  = vector_valid_q;
  assign bus.isrOut       = isr_q;
endmodule

// File: tb/tb_priority_resolver_isr.sv
// Directed bench for priority_resolver_isr with hand-computed expectations.
module tb_priority_resolver_isr;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  priority_resolver_isr_if bus ();

  priority_resolver_isr dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic ocw2_cmd(input logic [7:0] val);
    bus.ocw2      = val;
    bus.ocw2Valid = 1'b1;
    step();
    bus.ocw2Valid = 1'b0;
  endtask

  task automatic inta_on();
    bus.intaPulse = 1'b1;
    step();
    bus.intaPulse = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.risedBits  = 8'h00;
    bus.bitToMask  = 8'h00;
    bus.intaPulse  = 1'b0;
    bus.icw2Vector = 5'h11;
    bus.aeoi       = 1'b0;
    bus.ocw2Valid  = 1'b0;
    bus.ocw2       = 8'h00;
    step();
    step();
    check("rst_int", bus.intOut, 1'b0);
    check("rst_isr", bus.isrOut, 8'h00);
    check("rst_vec", bus.vectorOut, 8'h00);
    check("rst_vv", bus.vectorValid, 1'b0);
    check("rst_rp", bus.readPriority, 1'b0);
    check("rst_rirr", bus.resetIRR, 3'd0);
    reset = 1'b0;
    step();

    // Basic: IR2 wins over IR5
    bus.risedBits = 8'h24;
    check("basic_int_pre", bus.intOut, 1'b0);
    step();
    check("basic_int", bus.intOut, 1'b1);
    inta_on();
    check("basic_isr", bus.isrOut, 8'h04);
    check("basic_rirr", bus.resetIRR, 3'd2);
    check("basic_rp", bus.readPriority, 1'b1);
    bus.risedBits = 8'h20;
    step();
    check("basic_rp_off", bus.readPriority, 1'b0);
    check("basic_int_hold", bus.intOut, 1'b1);
    inta_on();
    check("basic_vec", bus.vectorOut, 8'h8A);
    check("basic_vv", bus.vectorValid, 1'b1);
    check("basic_int_off", bus.intOut, 1'b0);
    step();
    check("basic_vv_off", bus.vectorValid, 1'b0);
    step();
    check("basic_ir5_blocked", bus.intOut, 1'b0);
    bus.risedBits = 8'h00;
    ocw2_cmd(8'h20);
    check("basic_eoi", bus.isrOut, 8'h00);

    // Nesting: IR3 in service, IR5 blocked, IR1 nests
    bus.risedBits = 8'h08;
    step();
    inta_on();
    bus.risedBits = 8'h00;
    inta_on();
    check("nest_vec3", bus.vectorOut, 8'h8B);
    check("nest_isr3", bus.isrOut, 8'h08);
    bus.risedBits = 8'h20;
    step();
    step();
    check("nest_ir5_blocked", bus.intOut, 1'b0);
    bus.risedBits = 8'h08;
    step();
    step();
    check("nest_ir3_equal", bus.intOut, 1'b0);
    bus.risedBits = 8'h02;
    step();
    check("nest_ir1_int", bus.intOut, 1'b1);
    inta_on();
    check("nest_isr", bus.isrOut, 8'h0A);
    check("nest_rirr", bus.resetIRR, 3'd1);
    bus.risedBits = 8'h00;
    inta_on();
    check("nest_vec1", bus.vectorOut, 8'h89);
    ocw2_cmd(8'h20);
    check("nest_eoi1", bus.isrOut, 8'h08);
    ocw2_cmd(8'h20);
    check("nest_eoi2", bus.isrOut, 8'h00);
    ocw2_cmd(8'h20);
    check("ns_eoi_empty", bus.isrOut, 8'h00);

    // Spurious: request withdrawn after INT
    bus.risedBits = 8'h10;
    step();
    check("spur_int", bus.intOut, 1'b1);
    bus.risedBits = 8'h00;
    step();
    check("spur_int_hold", bus.intOut, 1'b1);
    inta_on();
    check("spur_rp", bus.readPriority, 1'b0);
    check("spur_isr", bus.isrOut, 8'h00);
    inta_on();
    check("spur_vec", bus.vectorOut, 8'h8F);
    check("spur_vv", bus.vectorValid, 1'b1);

    // EOIs: build ISR = 09 (IR3 then IR0)
    bus.risedBits = 8'h08;
    step();
    inta_on();
    bus.risedBits = 8'h01;
    inta_on();
    step();
    inta_on();
    bus.risedBits = 8'h00;
    inta_on();
    check("eoi_isr09", bus.isrOut, 8'h09);
    ocw2_cmd(8'h20);
    check("eoi_ns", bus.isrOut, 8'h08);
    ocw2_cmd(8'h63);
    check("eoi_sp", bus.isrOut, 8'h00);
    ocw2_cmd(8'hC2);
    bus.risedBits = 8'h09;
    step();
    check("pri_int", bus.intOut, 1'b1);
    inta_on();
    check("pri_rirr", bus.resetIRR, 3'd3);
    check("pri_isr", bus.isrOut, 8'h08);
    bus.risedBits = 8'h01;
    inta_on();
    check("pri_vec", bus.vectorOut, 8'h8B);
    step();
    check("pri_ir0_blocked", bus.intOut, 1'b0);
    bus.risedBits = 8'h00;
    ocw2_cmd(8'h63);
    ocw2_cmd(8'hC7);
    check("pri_clear", bus.isrOut, 8'h00);

    // AEOI with rotation
    bus.aeoi = 1'b1;
    ocw2_cmd(8'h80);
    bus.risedBits = 8'h10;
    step();
    inta_on();
    check("aeoi_isr4", bus.isrOut, 8'h10);
    bus.risedBits = 8'h00;
    inta_on();
    check("aeoi_vec4", bus.vectorOut, 8'h8C);
    check("aeoi_isr_clr", bus.isrOut, 8'h00);
    bus.risedBits = 8'h30;
    step();
    check("aeoi_int", bus.intOut, 1'b1);
    inta_on();
    check("aeoi_rot_rirr", bus.resetIRR, 3'd5);
    check("aeoi_isr5", bus.isrOut, 8'h20);
    bus.risedBits = 8'h10;
    inta_on();
    check("aeoi_vec5", bus.vectorOut, 8'h8D);
    check("aeoi_isr5_clr", bus.isrOut, 8'h00);
    bus.risedBits = 8'h00;
    bus.aeoi = 1'b0;
    ocw2_cmd(8'h00);
    ocw2_cmd(8'hC7);

    // Reset in ACK2
    bus.risedBits = 8'h01;
    step();
    inta_on();
    check("rst2_isr_pre", bus.isrOut, 8'h01);
    reset = 1'b1;
    #1;
    check("rst2_int", bus.intOut, 1'b0);
    check("rst2_isr", bus.isrOut, 8'h00);
    check("rst2_rp", bus.readPriority, 1'b0);
    check("rst2_rirr", bus.resetIRR, 3'd0);
    step();
    reset = 1'b0;
    bus.risedBits = 8'h00;
    inta_on();
    check("rst2_no_vv", bus.vectorValid, 1'b0);
    check("rst2_vec", bus.vectorOut, 8'h00);
    check("rst2_int_idle", bus.intOut, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/priority_resolver_isr.md
Name: priority_resolver_isr

Overview:
- Downstream neighbour of the Interrupt Request Register. Takes its valid-request vector (risedBits) and the IMR mask, and resolves priority with fully-nested or rotating rules.
- Holds the In-Service Register (ISR) and runs the two-pulse INTA sequence. Drives INT to the CPU and places the interrupt vector on the data path.
- Returns the serviced level to the IRR (resetIRR plus a readPriority strobe) and executes OCW2 EOI and rotation commands.

Parameters:
- IR_COUNT, 8, number of request lines; only 8 is supported and the level encoding is 3 bits.
- SPURIOUS_LEVEL, 7, level reported when INTA arrives with no request pending.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- risedBits  in  8  valid requests from the IRR, bit n = IRn.
- bitToMask  in  8  IMR; a 1 masks that level from resolution.
- intaPulse  in  1  one-clk strobe per INTA falling edge, synchronised upstream.
- icw2Vector  in  5  T7..T3 from ICW2.
- aeoi  in  1  ICW4 AEOI bit.
- ocw2Valid  in  1  one-clk strobe: ocw2 holds a new command.
- ocw2  in  8  OCW2 byte; bit7 R, bit6 SL, bit5 EOI, bits2:0 L2..L0.
- intOut  out  1  INT request to the CPU.
- resetIRR  out  3  level to clear in the IRR.
- readPriority  out  1  one-clk strobe: IRR clears level resetIRR.
- vectorOut  out  8  interrupt vector.
- vectorValid  out  1  one-clk strobe: vectorOut is valid.
- isrOut  out  8  current ISR contents, readable by control logic.

Behaviour:
- Reset values:
  - ISR = 0, lowestPri = 7 (so IR0 is highest), rotateAeoi = 0, state = IDLE.
  - intOut = 0, readPriority = 0, vectorValid = 0, resetIRR = 0, vectorOut = 0.
  - Reset mid-sequence returns to IDLE immediately and never emits a vector.
- Priority order: starts at (lowestPri+1) mod 8 and wraps, so the search from IR(lowestPri+1) around to IRlowestPri is the full order.
- Resolution (combinational):
  - pend = risedBits & ~bitToMask.
  - cand = first set bit of pend in priority order.
  - curIS = first set bit of ISR in the same order.
  - request = cand exists and (ISR == 0 or cand is strictly higher priority than curIS). An equal level blocks.
- IDLE:
  - When request is true, intOut goes to 1 on the next edge (1-clk latency) and state moves to ACK1.
- ACK1:
  - intOut is held at 1 even if the request is withdrawn.
  - On intaPulse, latch lvl = cand if a candidate exists at that edge; otherwise lvl = SPURIOUS_LEVEL and spurious = 1.
  - If not spurious: set ISR[lvl], drive resetIRR = lvl, pulse readPriority for 1 clk.
  - In both cases move to ACK2.
- ACK2:
  - On intaPulse: vectorOut = {icw2Vector, lvl}, vectorValid = 1 for 1 clk, intOut = 0, state = IDLE.
  - If aeoi and not spurious, clear ISR[lvl] on the same edge; if rotateAeoi is also set, lowestPri = lvl.
- IDLE re-evaluates resolution on the cycle after returning, so back-to-back interrupts are allowed.
- OCW2 (acted on only when ocw2Valid; R/SL/EOI):
  - 001: non-specific EOI, clear ISR[curIS].
  - 011: specific EOI, clear ISR[L].
  - 101: rotate on non-specific EOI, clear ISR[curIS] and set lowestPri = curIS.
  - 111: rotate on specific EOI, clear ISR[L] and set lowestPri = L.
  - 110: set priority, lowestPri = L.
  - 100: rotateAeoi = 1.
  - 000: rotateAeoi = 0.
  - 010: no-op.
  - A non-specific EOI with ISR == 0 has no effect.
- Simultaneous events:
  - An OCW2 in the same cycle as the first intaPulse: the EOI clear and the new ISR set both apply. Setting wins if they target the same bit.
  - Priority changes take effect for resolution on the next cycle; lvl already latched is unaffected.
- intaPulse in IDLE is ignored.
- Only one interrupt is in flight at a time; requests are not re-resolved in ACK2.

Decomposition:
- Shared package pic_pkg holds:
  - the state enum (IDLE, ACK1, ACK2);
  - OCW2 field bit positions and command encodings;
  - IR_COUNT and SPURIOUS_LEVEL;
  - a function rotPriority(vector, lowestPri) returning {found, level}.
- One sub-module, priority_encoder_rot: combinational rotating first-set-bit finder, instantiated twice (pend and ISR).

Test Plan:
- Basic: risedBits=8'h24, mask=0. intOut rises 1 clk later; INTA #1 sets isrOut=8'h04, resetIRR=2 plus a readPriority pulse; INTA #2 with icw2Vector=5'h11 gives vectorOut=8'h8A.
- Nesting: ISR=8'h08 (IR3). risedBits=8'h20 gives no intOut; risedBits=8'h02 asserts intOut and ends with ISR=8'h0A.
- Spurious: the request drops after intOut=1. INTA pair gives vectorOut={T,3'd7}, isrOut unchanged, and no readPriority.
- AEOI with rotation: aeoi=1 and ocw2=8'h80 applied, IR4 serviced. ISR returns to 0 after INTA #2 and lowestPri=4; IR4 and IR5 then pending gives IR5 serviced first.
- EOIs:
  - ISR=8'h09, ocw2=8'h20 gives 8'h08.
  - ocw2=8'h63 gives 8'h00.
  - ocw2=8'hC2 sets lowestPri=2, so IR3 becomes highest.
- Reset asserted in ACK2: outputs return to their reset values asynchronously, and no vectorValid follows on the next intaPulse.
